// File: rtl/ram_loader_pkg.sv
// Shared definitions for the front-panel RAM loader: bus width defaults and
// the loader FSM state encoding.
package ram_loader_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LOAD_IDLE = 3'd1,
    ST_WRITE     = 3'd2,
    ST_ADVANCE   = 3'd3,
    ST_DRAIN     = 3'd4
  } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// RAM bus as seen by the loader: CPU-side request inputs and RAM-side outputs.
// The master modport is the loader; the slave modport is the CPU/RAM side.
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic [AW-1:0] CPU_MADDR;
  logic [DW-1:0] CPU_DATA;
  logic          CPU_RD;
  logic          CPU_WR;

  logic [AW-1:0] MADDR;
  logic [DW-1:0] DATA_O;
  logic          RD;
  logic          WR;

  modport master (
    input  CPU_MADDR, CPU_DATA, CPU_RD, CPU_WR,
    output MADDR, DATA_O, RD, WR
  );

  modport slave (
    output CPU_MADDR, CPU_DATA, CPU_RD, CPU_WR,
    input  MADDR, DATA_O, RD, WR
  );

endinterface

// File: rtl/ram_loader_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous push button followed by a
// rising-edge detector producing a one-cycle pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Pulse is live in the cycle right after the second sync flop rises.
  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/ram_loader.sv
// Front-panel program loader: in load mode holds the CPU off and writes
// switch bytes to consecutive RAM addresses; in run mode passes the CPU bus.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 2**AW - 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD_MODE,
  input  logic          STROBE,
  input  logic [DW-1:0] DIN,
  ram_loader_if.master  bus,
  output logic          CPU_HOLD,
  output logic [AW-1:0] LOAD_PTR,
  output logic [AW:0]   COUNT,
  output logic          FULL
);

  localparam logic [AW-1:0] START_PTR = START_ADDR[AW-1:0];
  localparam logic [AW-1:0] LAST_PTR  = LAST_ADDR[AW-1:0];

  loader_state_t r_state;
  loader_state_t w_next;
  logic          w_pulse;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic [DW-1:0] r_data;

  sync_edge_detect u_strobe (
    .clk     (CLK),
    .rst     (RST),
    .i_async (STROBE),
    .o_pulse (w_pulse)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // A mode fall in LOAD_IDLE takes priority over a simultaneous strobe.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:       if (LOAD_MODE) w_next = ST_LOAD_IDLE;
      ST_LOAD_IDLE: begin
        if (!LOAD_MODE) begin
          w_next = ST_DRAIN;
        end else if (w_pulse && !r_full) begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE:     w_next = ST_ADVANCE;
      ST_ADVANCE:   w_next = LOAD_MODE ? ST_LOAD_IDLE : ST_DRAIN;
      ST_DRAIN:     w_next = ST_RUN;
      default:      w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= START_PTR;
      r_count <= '0;
      r_full  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (LOAD_MODE) begin
            r_ptr   <= START_PTR;
            r_count <= '0;
            r_full  <= 1'b0;
          end
        end
        ST_LOAD_IDLE: begin
          if (LOAD_MODE && w_pulse && !r_full) begin
            r_data <= DIN;
          end
        end
        ST_ADVANCE: begin
          r_count <= r_count + 1'b1;
          // The pointer parks on the last address instead of wrapping.
          if (r_ptr == LAST_PTR) begin
            r_full <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.MADDR  = bus.CPU_MADDR;
    bus.DATA_O = bus.CPU_DATA;
    bus.RD     = bus.CPU_RD;
    bus.WR     = bus.CPU_WR;
    CPU_HOLD   = 1'b0;
    if (r_state != ST_RUN) begin
      bus.MADDR  = r_ptr;
      bus.DATA_O = r_data;
      bus.RD     = 1'b0;
      bus.WR     = (r_state == ST_WRITE);
      CPU_HOLD   = 1'b1;
    end
  end

  assign LOAD_PTR = r_ptr;
  assign COUNT    = r_count;
  assign FULL     = r_full;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: a default instance and a two-byte instance
// (0xFE..0xFF) exercise pass-through, loading, exit races, resets and FULL.
module tb_ram_loader;

   logic       clock;
   logic       rst;
   logic       loadMode, strobe;
   logic [7:0] din;
   logic       loadModeF, strobeF;
   logic [7:0] dinF;
   logic       holdA, holdF, fullA, fullF;
   logic [7:0] ptrA, ptrF;
   logic [8:0] countA, countF;

   int checks = 0;
   int errors = 0;
   int wrCountA = 0;
   int wrCountF = 0;
   logic [15:0] expA[$];
   logic [15:0] expF[$];

   ram_loader_if #(.AW(8), .DW(8)) busA ();
   ram_loader_if #(.AW(8), .DW(8)) busF ();

   ram_loader u_dut (
      .CLK(clock), .RST(rst), .LOAD_MODE(loadMode), .STROBE(strobe), .DIN(din),
      .bus(busA), .CPU_HOLD(holdA), .LOAD_PTR(ptrA), .COUNT(countA), .FULL(fullA)
   );

   ram_loader #(.START_ADDR(8'hFE), .LAST_ADDR(8'hFF)) u_full (
      .CLK(clock), .RST(rst), .LOAD_MODE(loadModeF), .STROBE(strobeF), .DIN(dinF),
      .bus(busF), .CPU_HOLD(holdF), .LOAD_PTR(ptrF), .COUNT(countF), .FULL(fullF)
   );

   // 100 MHz clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts one comparison and reports it when the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Scoreboard for the default instance: every loader write must match the queue head
   always @(negedge clock) begin
      if (holdA && busA.WR) begin
         wrCountA++;
         if (expA.size() == 0) checkOutput("unexpected WR (A)", 32'd1, 32'd0);
         else checkOutput("A write addr/data", {16'd0, busA.MADDR, busA.DATA_O}, {16'd0, expA.pop_front()});
      end
   end

   // Scoreboard for the two-byte instance
   always @(negedge clock) begin
      if (holdF && busF.WR) begin
         wrCountF++;
         if (expF.size() == 0) checkOutput("unexpected WR (F)", 32'd1, 32'd0);
         else checkOutput("F write addr/data", {16'd0, busF.MADDR, busF.DATA_O}, {16'd0, expF.pop_front()});
      end
   end

   // One clock step, leaving the bench on the following falling edge
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic wrOf(input bit sel);
      return sel ? busF.WR : busA.WR;
   endfunction

   // Presses the strobe once and checks that WR appears exactly two edges
   // after the sampling edge (n+2) and nowhere else around it
   task automatic applyStimulus(input bit sel, input logic [7:0] value,
                                input bit expectWrite, input logic [7:0] expAddr);
      @(negedge clock);
      if (sel) begin
         dinF = value; strobeF = 1'b1;
         if (expectWrite) expF.push_back({expAddr, value});
      end else begin
         din = value; strobe = 1'b1;
         if (expectWrite) expA.push_back({expAddr, value});
      end
      tick();
      checkOutput("WR after edge n", {31'd0, wrOf(sel)}, 32'd0);
      checkOutput("RD held low", {31'd0, sel ? busF.RD : busA.RD}, 32'd0);
      tick();
      checkOutput("WR after edge n+1", {31'd0, wrOf(sel)}, 32'd0);
      tick();
      checkOutput("WR after edge n+2", {31'd0, wrOf(sel)}, {31'd0, expectWrite});
      if (sel) strobeF = 1'b0; else strobe = 1'b0;
      tick();
      checkOutput("WR after edge n+3", {31'd0, wrOf(sel)}, 32'd0);
      tick();
      tick();
   endtask

   // Drives the whole scenario sequence and prints the summary
   initial begin
      rst = 1'b1;
      loadMode = 1'b0; strobe = 1'b0; din = 8'h00;
      loadModeF = 1'b0; strobeF = 1'b0; dinF = 8'h00;
      busA.CPU_MADDR = 8'h00; busA.CPU_DATA = 8'h00; busA.CPU_RD = 1'b0; busA.CPU_WR = 1'b0;
      busF.CPU_MADDR = 8'h00; busF.CPU_DATA = 8'h00; busF.CPU_RD = 1'b0; busF.CPU_WR = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      checkOutput("reset CPU_HOLD", {31'd0, holdA}, 32'd0);
      checkOutput("reset LOAD_PTR", {24'd0, ptrA}, 32'h00);
      checkOutput("reset COUNT", {23'd0, countA}, 32'd0);
      checkOutput("reset FULL", {31'd0, fullA}, 32'd0);
      checkOutput("reset LOAD_PTR (F)", {24'd0, ptrF}, 32'hFE);

      // Run-mode pass-through with zero latency
      busA.CPU_MADDR = 8'h12; busA.CPU_DATA = 8'h34; busA.CPU_WR = 1'b1;
      #1;
      checkOutput("run MADDR", {24'd0, busA.MADDR}, 32'h12);
      checkOutput("run DATA_O", {24'd0, busA.DATA_O}, 32'h34);
      checkOutput("run WR", {31'd0, busA.WR}, 32'd1);
      checkOutput("run CPU_HOLD", {31'd0, holdA}, 32'd0);
      busA.CPU_WR = 1'b0; busA.CPU_RD = 1'b1;
      #1;
      checkOutput("run RD", {31'd0, busA.RD}, 32'd1);

      // Load three bytes while the CPU keeps requesting the bus
      busA.CPU_WR = 1'b1;
      @(negedge clock);
      loadMode = 1'b1;
      tick();
      checkOutput("load CPU_HOLD", {31'd0, holdA}, 32'd1);
      checkOutput("load WR ignores CPU", {31'd0, busA.WR}, 32'd0);
      checkOutput("load MADDR=ptr", {24'd0, busA.MADDR}, 32'h00);
      applyStimulus(1'b0, 8'hA1, 1'b1, 8'h00);
      applyStimulus(1'b0, 8'hB2, 1'b1, 8'h01);
      applyStimulus(1'b0, 8'hC3, 1'b1, 8'h02);
      checkOutput("load3 LOAD_PTR", {24'd0, ptrA}, 32'd3);
      checkOutput("load3 COUNT", {23'd0, countA}, 32'd3);
      checkOutput("load3 WR cycles", wrCountA, 32'd3);

      // Exit race: mode falls on the edge that sees the strobe pulse
      din = 8'hEE; strobe = 1'b1;
      tick();
      tick();
      loadMode = 1'b0;
      tick();
      checkOutput("drain CPU_HOLD", {31'd0, holdA}, 32'd1);
      checkOutput("drain WR", {31'd0, busA.WR}, 32'd0);
      checkOutput("drain RD", {31'd0, busA.RD}, 32'd0);
      strobe = 1'b0;
      tick();
      checkOutput("post-drain CPU_HOLD", {31'd0, holdA}, 32'd0);
      checkOutput("post-drain WR pass", {31'd0, busA.WR}, 32'd1);
      checkOutput("post-drain MADDR pass", {24'd0, busA.MADDR}, 32'h12);
      checkOutput("race COUNT", {23'd0, countA}, 32'd3);
      checkOutput("race WR cycles", wrCountA, 32'd3);
      busA.CPU_WR = 1'b0; busA.CPU_RD = 1'b0;
      tick(); tick(); tick();

      // Mode fall during WRITE: write completes, ADVANCE counts, then DRAIN
      loadMode = 1'b1;
      tick();
      checkOutput("re-entry LOAD_PTR", {24'd0, ptrA}, 32'h00);
      checkOutput("re-entry COUNT", {23'd0, countA}, 32'd0);
      din = 8'h5A; strobe = 1'b1; expA.push_back({8'h00, 8'h5A});
      tick(); tick(); tick();
      checkOutput("fall WRITE WR", {31'd0, busA.WR}, 32'd1);
      loadMode = 1'b0; strobe = 1'b0;
      tick();
      checkOutput("fall ADVANCE WR", {31'd0, busA.WR}, 32'd0);
      tick();
      checkOutput("fall COUNT", {23'd0, countA}, 32'd1);
      checkOutput("fall LOAD_PTR", {24'd0, ptrA}, 32'd1);
      checkOutput("fall DRAIN hold", {31'd0, holdA}, 32'd1);
      tick();
      checkOutput("fall RUN hold", {31'd0, holdA}, 32'd0);
      tick(); tick(); tick();

      // Reset in the middle of WRITE
      loadMode = 1'b1;
      tick();
      din = 8'h77; strobe = 1'b1; expA.push_back({8'h00, 8'h77});
      tick(); tick(); tick();
      checkOutput("rst WRITE WR", {31'd0, busA.WR}, 32'd1);
      rst = 1'b1; loadMode = 1'b0; strobe = 1'b0;
      tick();
      checkOutput("rst WR cut", {31'd0, busA.WR}, 32'd0);
      checkOutput("rst CPU_HOLD", {31'd0, holdA}, 32'd0);
      checkOutput("rst LOAD_PTR", {24'd0, ptrA}, 32'h00);
      checkOutput("rst COUNT", {23'd0, countA}, 32'd0);
      checkOutput("rst FULL", {31'd0, fullA}, 32'd0);
      rst = 1'b0;
      tick(); tick();

      // Two-byte buffer: third press is ignored once FULL
      loadModeF = 1'b1;
      tick();
      checkOutput("F start LOAD_PTR", {24'd0, ptrF}, 32'hFE);
      applyStimulus(1'b1, 8'h11, 1'b1, 8'hFE);
      applyStimulus(1'b1, 8'h22, 1'b1, 8'hFF);
      checkOutput("F FULL", {31'd0, fullF}, 32'd1);
      checkOutput("F LOAD_PTR", {24'd0, ptrF}, 32'hFF);
      checkOutput("F COUNT", {23'd0, countF}, 32'd2);
      applyStimulus(1'b1, 8'h33, 1'b0, 8'h00);
      checkOutput("F COUNT after 3rd", {23'd0, countF}, 32'd2);
      checkOutput("F WR cycles", wrCountF, 32'd2);
      loadModeF = 1'b0;
      tick(); tick();

      checkOutput("A scoreboard drained", expA.size(), 32'd0);
      checkOutput("F scoreboard drained", expF.size(), 32'd0);
      checkOutput("A total WR cycles", wrCountA, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
